// File: rtl/serial_to_parallel_rx.sv
// Receive side of the TTC bit-serial framing link: assembles MSB-first bytes from a gated
// serial stream, writes them to the frame buffer and checks the frame length.
module serial_to_parallel_rx #(
    parameter int FRAME_BITS  = 2024,
    parameter int ADDR_W      = 8,
    parameter bit PAD_PARTIAL = 1'b1
) (
    input  logic              ClkI,
    input  logic              Rst,
    input  logic              EnI,
    input  logic              DataI,
    output logic [7:0]        DataO,
    output logic              WrEnO,
    output logic [ADDR_W-1:0] WrAddrO,
    output logic              FrameDoneO,
    output logic              FrameErrO,
    output logic [15:0]       BitCntO
);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        FULL,
        OVER
    } state_t;

    localparam logic [15:0] FrameBitsC = 16'(FRAME_BITS);

    state_t              state_q, state_d;
    logic [7:0]          shift_q, shift_d;
    logic [2:0]          nbits_q, nbits_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          data_q, data_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [15:0]         bit_cnt_q, bit_cnt_d;

    logic [7:0]          shifted;
    logic [2:0]          pad_shift;
    logic [7:0]          pad_data;
    logic [15:0]         bit_cnt_inc;
    logic [15:0]         bit_cnt_sat;

    // Pending bits sit right-aligned in the shift register; moving them up by (8 - n)
    // left-aligns them and zero-fills the tail for a partial-byte flush.
    assign shifted     = {shift_q[6:0], DataI};
    assign pad_shift   = 3'd0 - nbits_q;
    assign pad_data    = shift_q << pad_shift;
    assign bit_cnt_inc = bit_cnt_q + 16'd1;
    assign bit_cnt_sat = (bit_cnt_q == 16'hFFFF) ? bit_cnt_q : bit_cnt_inc;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        nbits_d   = nbits_q;
        addr_d    = addr_q;
        data_d    = data_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        done_d    = 1'b0;
        err_d     = err_q;
        bit_cnt_d = bit_cnt_q;

        case (state_q)
            IDLE: begin
                if (EnI) begin
                    state_d   = RECV;
                    shift_d   = {7'd0, DataI};
                    nbits_d   = 3'd1;
                    bit_cnt_d = 16'd1;
                    err_d     = 1'b0;
                    addr_d    = '0;
                end
            end
            RECV: begin
                if (EnI) begin
                    shift_d   = shifted;
                    nbits_d   = nbits_q + 3'd1;
                    bit_cnt_d = bit_cnt_inc;
                    if (nbits_q == 3'd7) begin
                        data_d    = shifted;
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        addr_d    = addr_q + 1'b1;
                    end
                    if (bit_cnt_inc == FrameBitsC) begin
                        state_d = FULL;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    nbits_d = 3'd0;
                    if (PAD_PARTIAL && nbits_q != 3'd0) begin
                        data_d    = pad_data;
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        addr_d    = addr_q + 1'b1;
                    end
                end
            end
            FULL: begin
                if (EnI) begin
                    state_d   = OVER;
                    err_d     = 1'b1;
                    bit_cnt_d = bit_cnt_sat;
                end else begin
                    state_d = IDLE;
                end
            end
            OVER: begin
                if (EnI) begin
                    bit_cnt_d = bit_cnt_sat;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ClkI or negedge Rst) begin
        if (!Rst) begin
            state_q   <= IDLE;
            shift_q   <= 8'd0;
            nbits_q   <= 3'd0;
            addr_q    <= '0;
            data_q    <= 8'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            bit_cnt_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            nbits_q   <= nbits_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            done_q    <= done_d;
            err_q     <= err_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign DataO      = data_q;
    assign WrEnO      = wr_en_q;
    assign WrAddrO    = wr_addr_q;
    assign FrameDoneO = done_q;
    assign FrameErrO  = err_q;
    assign BitCntO    = bit_cnt_q;

endmodule
